// File: rtl/fmap_stream_tx_pkg.sv
// Shared types and helpers for the feature-map stream transmitter.
package fmap_stream_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_HSYNC,
    ST_ROW,
    ST_GAP
  } tx_state_e;

  localparam int VS_LEN_DEF = 4;

  function automatic int addr_w(input int size, input int channel);
    return (size * size * channel > 1) ? $clog2(size * size * channel) : 1;
  endfunction

endpackage

// File: rtl/fmap_stream_tx_stream_align.sv
// One-stage alignment of stream controls so they coincide with the RAM read data
// returned for the address issued in the previous cycle.
module stream_align #(
  parameter int WIDTH_D = 27
) (
  input  logic               i_sclk,
  input  logic               i_rst_n,
  input  logic               vsync_c,
  input  logic               hsync_c,
  input  logic               reuse_c,
  input  logic               valid_c,
  input  logic [WIDTH_D-1:0] rd_data,
  output logic               vsync,
  output logic               hsync,
  output logic               reuse,
  output logic               valid,
  output logic [WIDTH_D-1:0] tdata
);

  always_ff @(posedge i_sclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vsync <= 1'b0;
      hsync <= 1'b0;
      reuse <= 1'b0;
      valid <= 1'b0;
    end else begin
      vsync <= vsync_c;
      hsync <= hsync_c;
      reuse <= reuse_c;
      valid <= valid_c;
    end
  end

  // rd_data already comes off the RAM output register; only force zero between beats.
  assign tdata = valid ? rd_data : '0;

endmodule

// File: rtl/fmap_stream_tx.sv
// Feature-map stream transmitter: replays a stored feature map from single-port RAM
// as the vsync/hsync/reuse/valid raster stream feeding the next layer's window groups.
//
// state    | meaning
// ST_IDLE  | waiting for i_start
// ST_VSYNC | frame-start window, VS_LEN cycles, counters cleared
// ST_HSYNC | one-cycle row start
// ST_ROW   | SIZE*CHANNEL read beats of one row
// ST_GAP   | GAP idle cycles after a row
module fmap_stream_tx
  import fmap_stream_tx_pkg::*;
#(
  parameter int WIDTH_D = 27,
  parameter int SIZE    = 28,
  parameter int CHANNEL = 128,
  parameter int GAP     = 0,
  parameter int REPEAT  = 1,
  parameter int VS_LEN  = VS_LEN_DEF,
  parameter int ADDR_W  = addr_w(SIZE, CHANNEL)
) (
  input  logic               i_sclk,
  input  logic               i_rst_n,
  input  logic               i_start,
  output logic [ADDR_W-1:0]  o_rd_addr,
  output logic               o_rd_en,
  input  logic [WIDTH_D-1:0] i_rd_data,
  output logic               o_vsync,
  output logic               o_hsync,
  output logic               o_reuse,
  output logic               o_valid,
  output logic [WIDTH_D-1:0] o_tdata,
  output logic               o_busy,
  output logic               o_done
);

  localparam int ROW_LEN = SIZE * CHANNEL;
  localparam int TMR_MAX = (ROW_LEN > VS_LEN) ? ((ROW_LEN > GAP) ? ROW_LEN : GAP)
                                              : ((VS_LEN > GAP) ? VS_LEN : GAP);
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int ROW_W   = $clog2(SIZE + 1);
  localparam int REP_W   = $clog2(REPEAT + 1);

  tx_state_e         state_q, state_nxt;
  logic [TMR_W-1:0]  tmr_q, tmr_load;
  logic [ROW_W-1:0]  row_q;
  logic [REP_W-1:0]  rep_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rd_en_q, busy_q, done_q, done_out_q;
  logic              start_acc, tc, last_row, last_rep, frame_end, enter;
  logic              vsync_c, hsync_c, valid_c, reuse_c;

  // A start held through the tail of a frame must not retrigger it.
  assign start_acc = (state_q == ST_IDLE) && i_start && !busy_q && !done_out_q;
  assign tc        = (tmr_q == '0);
  assign last_row  = (row_q == ROW_W'(SIZE - 1));
  assign last_rep  = (rep_q == REP_W'(REPEAT - 1));
  assign enter     = (state_nxt != state_q);

  always_ff @(posedge i_sclk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    frame_end = 1'b0;
    case (state_q)
      ST_IDLE:  if (start_acc) state_nxt = ST_VSYNC;
      ST_VSYNC: if (tc) state_nxt = ST_HSYNC;
      ST_HSYNC: state_nxt = ST_ROW;
      ST_ROW: begin
        if (tc) begin
          if (GAP > 0)       state_nxt = ST_GAP;
          else if (!last_row) state_nxt = ST_HSYNC;
          else               frame_end = 1'b1;
        end
      end
      ST_GAP: begin
        if (tc) begin
          if (!last_row) state_nxt = ST_HSYNC;
          else           frame_end = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (frame_end) state_nxt = last_rep ? ST_IDLE : ST_VSYNC;
  end

  always_comb begin
    vsync_c = (state_q == ST_VSYNC);
    hsync_c = (state_q == ST_HSYNC);
    valid_c = (state_q == ST_ROW);
    reuse_c = (state_q == ST_ROW) && (rep_q != '0);
  end

  always_comb begin
    tmr_load = '0;
    case (state_nxt)
      ST_VSYNC: tmr_load = TMR_W'(VS_LEN - 1);
      ST_ROW:   tmr_load = TMR_W'(ROW_LEN - 1);
      ST_GAP:   tmr_load = TMR_W'((GAP > 0) ? GAP - 1 : 0);
      default:  tmr_load = '0;
    endcase
  end

  always_ff @(posedge i_sclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tmr_q  <= '0;
      row_q  <= '0;
      rep_q  <= '0;
      addr_q <= '0;
    end else begin
      if (enter)    tmr_q <= tmr_load;
      else if (!tc) tmr_q <= tmr_q - 1'b1;

      if (start_acc)                   rep_q <= '0;
      else if (frame_end && !last_rep) rep_q <= rep_q + 1'b1;

      if (enter && state_nxt == ST_VSYNC) begin
        row_q  <= '0;
        addr_q <= '0;
      end else begin
        if (enter && state_nxt == ST_HSYNC && state_q != ST_VSYNC) row_q <= row_q + 1'b1;
        // hold the final address rather than wrapping past the end of the map
        if (state_q == ST_ROW && !(tc && last_row)) addr_q <= addr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_sclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      done_out_q <= 1'b0;
    end else begin
      rd_en_q    <= (state_nxt == ST_ROW);
      done_q     <= frame_end && last_rep;
      done_out_q <= done_q;
      if (start_acc)   busy_q <= 1'b1;
      else if (done_q) busy_q <= 1'b0;
    end
  end

  assign o_rd_addr = addr_q;
  assign o_rd_en   = rd_en_q;
  assign o_busy    = busy_q;
  assign o_done    = done_out_q;

  stream_align #(.WIDTH_D(WIDTH_D)) u_align (
    .i_sclk  (i_sclk),
    .i_rst_n (i_rst_n),
    .vsync_c (vsync_c),
    .hsync_c (hsync_c),
    .reuse_c (reuse_c),
    .valid_c (valid_c),
    .rd_data (i_rd_data),
    .vsync   (o_vsync),
    .hsync   (o_hsync),
    .reuse   (o_reuse),
    .valid   (o_valid),
    .tdata   (o_tdata)
  );

endmodule

// File: tb/tb_fmap_stream_tx.sv
// Bench for fmap_stream_tx: four parameterisations driven from one initial block,
// each frame compared cycle by cycle against a stream built from the raster rules.
module tb_fmap_stream_tx;

  localparam int ND = 4;
  localparam int WD = 27;
  localparam int P_SIZE [ND] = '{2, 2, 3, 28};
  localparam int P_CH   [ND] = '{2, 2, 2, 8};
  localparam int P_GAP  [ND] = '{1, 0, 2, 0};
  localparam int P_REP  [ND] = '{1, 1, 3, 1};
  localparam int P_VS   [ND] = '{2, 2, 3, 4};

  typedef struct {
    logic vs;
    logic hs;
    logic va;
    logic re;
    logic dn;
    int   addr;
  } exp_t;

  logic                  sclk = 1'b0;
  logic                  rst_n;
  logic [ND-1:0]         start;
  logic [ND-1:0]         vs, hs, re, va, dn, bs, rd_en;
  logic [ND-1:0][31:0]   rd_addr;
  logic [ND-1:0][WD-1:0] tdata, ram_q;
  logic [31:0]           salt [ND];
  exp_t                  eq[$];
  int                    n_chk = 0;
  int                    n_fail = 0;

  always #5 sclk = ~sclk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    localparam int AW = $clog2(P_SIZE[g] * P_SIZE[g] * P_CH[g]);
    logic [AW-1:0] dut_addr;
    fmap_stream_tx #(
      .WIDTH_D(WD), .SIZE(P_SIZE[g]), .CHANNEL(P_CH[g]), .GAP(P_GAP[g]),
      .REPEAT(P_REP[g]), .VS_LEN(P_VS[g]), .ADDR_W(AW)
    ) u_dut (
      .i_sclk(sclk), .i_rst_n(rst_n), .i_start(start[g]),
      .o_rd_addr(dut_addr), .o_rd_en(rd_en[g]), .i_rd_data(ram_q[g]),
      .o_vsync(vs[g]), .o_hsync(hs[g]), .o_reuse(re[g]), .o_valid(va[g]),
      .o_tdata(tdata[g]), .o_busy(bs[g]), .o_done(dn[g])
    );
    assign rd_addr[g] = 32'(dut_addr);
  end

  function automatic logic [WD-1:0] ram_word(input int d, input int a);
    logic [31:0] h;
    h = (32'(a) * 32'h9E3779B1) ^ salt[d];
    return h[WD-1:0];
  endfunction

  // synchronous single-port RAM: data appears the cycle after the read enable
  always @(posedge sclk)
    for (int d = 0; d < ND; d++)
      if (rd_en[d]) ram_q[d] <= ram_word(d, int'(rd_addr[d]));

  function automatic exp_t mk(input logic v, input logic h, input logic a,
                              input logic r, input logic n, input int addr);
    exp_t e;
    e.vs = v; e.hs = h; e.va = a; e.re = r; e.dn = n; e.addr = addr;
    return e;
  endfunction

  // expected output stream, one entry per cycle starting at the first o_vsync cycle
  task automatic build_exp(input int d);
    eq.delete();
    for (int r = 0; r < P_REP[d]; r++) begin
      for (int i = 0; i < P_VS[d]; i++) eq.push_back(mk(1, 0, 0, 0, 0, 0));
      for (int row = 0; row < P_SIZE[d]; row++) begin
        eq.push_back(mk(0, 1, 0, 0, 0, 0));
        for (int col = 0; col < P_SIZE[d]; col++)
          for (int ch = 0; ch < P_CH[d]; ch++)
            eq.push_back(mk(0, 0, 1, r > 0, 0, (row * P_SIZE[d] + col) * P_CH[d] + ch));
        for (int i = 0; i < P_GAP[d]; i++) eq.push_back(mk(0, 0, 0, 0, 0, 0));
      end
    end
    eq.push_back(mk(0, 0, 0, 0, 1, 0));
  endtask

  task automatic play_frame(input int d, input bit noise,
                            output int n_hs, output int n_va, output int max_a);
    exp_t        e, nx;
    logic [32:0] obs, expv, obs_rd, exp_rd;
    n_hs = 0; n_va = 0; max_a = -1;
    build_exp(d);
    repeat ($urandom_range(1, 3)) @(negedge sclk);
    start[d] = 1'b1;
    for (int j = 0; j <= eq.size(); j++) begin
      @(negedge sclk);
      e  = (j == 0) ? mk(0, 0, 0, 0, 0, 0) : eq[j-1];
      nx = (j < eq.size()) ? eq[j] : mk(0, 0, 0, 0, 0, 0);
      obs  = {vs[d], hs[d], re[d], va[d], dn[d], bs[d], tdata[d]};
      expv = {e.vs, e.hs, e.re, e.va, e.dn, (j == 0) ? 1'b1 : !e.dn,
              e.va ? ram_word(d, e.addr) : {WD{1'b0}}};
      n_chk++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL stream d%0d cyc%0d {vs,hs,re,va,done,busy,tdata}: got %h want %h",
                 d, j, obs, expv);
      end
      obs_rd = {rd_en[d], nx.va ? rd_addr[d] : 32'd0};
      exp_rd = {nx.va, nx.va ? 32'(nx.addr) : 32'd0};
      n_chk++;
      if (obs_rd !== exp_rd) begin
        n_fail++;
        $display("FAIL rd_port d%0d cyc%0d {rd_en,addr}: got %h want %h", d, j, obs_rd, exp_rd);
      end
      if (hs[d] === 1'b1) n_hs++;
      if (va[d] === 1'b1) n_va++;
      if (rd_en[d] === 1'b1 && int'(rd_addr[d]) > max_a) max_a = int'(rd_addr[d]);
      start[d] = noise ? ((j >= eq.size()) ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge sclk);
      start[d] = 1'b0;
      obs_rd = {vs[d], hs[d], re[d], va[d], dn[d], bs[d], rd_en[d], tdata[d][25:0]};
      n_chk++;
      if (obs_rd !== 33'd0 || tdata[d] !== '0) begin
        n_fail++;
        $display("FAIL idle_after d%0d cyc%0d outputs: got %h want 0", d, i, obs_rd);
      end
    end
  endtask

  task automatic test_reset();
    logic [65:0] obs;
    rst_n = 1'b0;
    start = '0;
    repeat (3) @(negedge sclk);
    for (int d = 0; d < ND; d++) begin
      obs = {vs[d], hs[d], re[d], va[d], dn[d], bs[d], rd_en[d], tdata[d], rd_addr[d]};
      n_chk++;
      if (obs !== 66'd0) begin
        n_fail++;
        $display("FAIL reset_state d%0d outputs: got %h want 0", d, obs);
      end
    end
    rst_n = 1'b1;
    @(negedge sclk);
  endtask

  task automatic test_single_frame();
    int nh, nv, ma;
    play_frame(0, 1'b0, nh, nv, ma);
    n_chk++;
    if (nh != 2 || nv != 8 || ma != 7) begin
      n_fail++;
      $display("FAIL single_frame counts hs/va/max: got %0d/%0d/%0d want 2/8/7", nh, nv, ma);
    end
  endtask

  task automatic test_gap0();
    int nh, nv, ma;
    play_frame(1, 1'b0, nh, nv, ma);
    n_chk++;
    if (nh != 2 || nv != 8 || ma != 7) begin
      n_fail++;
      $display("FAIL gap0 counts hs/va/max: got %0d/%0d/%0d want 2/8/7", nh, nv, ma);
    end
  endtask

  task automatic test_replay();
    int nh, nv, ma;
    play_frame(2, 1'b0, nh, nv, ma);
    n_chk++;
    if (nh != 3 * 3 || nv != 3 * 3 * 3 * 2 || ma != 17) begin
      n_fail++;
      $display("FAIL replay counts hs/va/max: got %0d/%0d/%0d want 9/54/17", nh, nv, ma);
    end
  endtask

  task automatic test_start_noise();
    int nh, nv, ma;
    play_frame(0, 1'b1, nh, nv, ma);
    play_frame(0, 1'b0, nh, nv, ma);
    n_chk++;
    if (nv != 8) begin
      n_fail++;
      $display("FAIL fresh_start valid beats: got %0d want 8", nv);
    end
  endtask

  task automatic test_reset_mid();
    logic [65:0] obs;
    int nh, nv, ma;
    repeat ($urandom_range(1, 3)) @(negedge sclk);
    start[0] = 1'b1;
    @(negedge sclk);
    start[0] = 1'b0;
    // twelve cycles on: second row, third beat, address 6
    repeat (12) @(negedge sclk);
    n_chk++;
    if ({va[0], tdata[0]} !== {1'b1, ram_word(0, 6)}) begin
      n_fail++;
      $display("FAIL pre_reset_beat {valid,tdata}: got %h want %h",
               {va[0], tdata[0]}, {1'b1, ram_word(0, 6)});
    end
    rst_n = 1'b0;
    #1;
    obs = {vs[0], hs[0], re[0], va[0], dn[0], bs[0], rd_en[0], tdata[0], rd_addr[0]};
    n_chk++;
    if (obs !== 66'd0) begin
      n_fail++;
      $display("FAIL async_reset outputs: got %h want 0", obs);
    end
    @(negedge sclk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge sclk);
      obs = {vs[0], hs[0], re[0], va[0], dn[0], bs[0], rd_en[0], tdata[0], rd_addr[0]};
      n_chk++;
      if (obs !== 66'd0) begin
        n_fail++;
        $display("FAIL post_reset_idle cyc%0d outputs: got %h want 0", i, obs);
      end
    end
    play_frame(0, 1'b0, nh, nv, ma);
    n_chk++;
    if (nv != 8 || ma != 7) begin
      n_fail++;
      $display("FAIL restart_after_reset va/max: got %0d/%0d want 8/7", nv, ma);
    end
  endtask

  task automatic test_large_map();
    int nh, nv, ma;
    play_frame(3, 1'b0, nh, nv, ma);
    n_chk++;
    if (nh != 28) begin
      n_fail++;
      $display("FAIL large_hsync_count: got %0d want 28", nh);
    end
    n_chk++;
    if (nv != 28 * 28 * 8) begin
      n_fail++;
      $display("FAIL large_valid_count: got %0d want %0d", nv, 28 * 28 * 8);
    end
    n_chk++;
    if (ma != 28 * 28 * 8 - 1) begin
      n_fail++;
      $display("FAIL large_max_addr: got %0d want %0d", ma, 28 * 28 * 8 - 1);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = '0;
    for (int d = 0; d < ND; d++) salt[d] = $urandom;
    test_reset();
    test_single_frame();
    test_gap0();
    test_replay();
    test_start_noise();
    test_reset_mid();
    test_large_map();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
